// File: rtl/task_queue_if.sv
// task_queue_if: push/pop handshake bundle between the core, the task queue and the dispatcher
interface task_queue_if #(parameter int WIDTH = 16);
    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;
    modport master (output push_valid, push_data, pop_ready, input push_ready, pop_valid, pop_data);
    modport slave  (input push_valid, push_data, pop_ready, output push_ready, pop_valid, pop_data);
endinterface

// File: rtl/task_queue.sv
// task_queue: FIFO of task start PCs with flush, drop counter and optional cut-through (TASK_QUEUE_BYPASS_EN)
module task_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    task_queue_if.slave            q,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             live, cut, wr, rd;

    // handshake outputs and transfer qualifiers; live keeps push_ready low until the first edge after reset
    always_comb begin
`ifdef TASK_QUEUE_BYPASS_EN
        cut = live && !flush && q.push_valid && count == '0;
`else
        cut = 1'b0;
`endif
        q.push_ready = live && !flush && count != FULL;
        q.pop_valid  = count != '0 || cut;
        q.pop_data   = cut ? q.push_data : mem[rd_ptr];
        wr = q.push_valid && q.push_ready && !(cut && q.pop_ready);
        rd = q.pop_valid && q.pop_ready && !flush && !cut;
    end

    // pointers, occupancy and drop counter; flush clears occupancy but never the drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (rd) rd_ptr <= rd_ptr + 1'b1;
                count <= (wr && !rd) ? count + 1'b1 : (rd && !wr) ? count - 1'b1 : count;
            end
            if (q.push_valid && !q.push_ready && !flush && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // entry storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= q.push_data;
    end
endmodule

// File: tb/tb_task_queue.sv
// tb_task_queue: randomized and directed checks of task_queue against a queue-based reference model
module tb_task_queue;
    localparam int D = 8;
    localparam int W = 16;
`ifdef TASK_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [3:0] count;
    logic [7:0] drop_cnt;
    task_queue_if #(.WIDTH(W)) bus();
    task_queue #(.DEPTH(D), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .q(bus.slave), .flush(flush), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [W-1:0] model [$];
    int m_drop = 0;
    bit up = 1'b0;
    logic [3:0] e_cnt, o_cnt;
    logic e_pv, o_pv, e_rdy, o_rdy;
    logic [7:0] e_drop, o_drop;
    logic [W-1:0] e_pd, o_pd;

    // drive one cycle, capture DUT outputs and model expectations before the edge, then advance the model
    task automatic step(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
        bit cut;
        bus.push_valid = pv; bus.push_data = pd; bus.pop_ready = pr; flush = fl;
        #1;
        cut    = BYP && up && !fl && pv && model.size() == 0;
        e_cnt  = 4'(model.size());
        e_pv   = model.size() > 0 || cut;
        e_pd   = cut ? pd : (model.size() > 0 ? model[0] : '0);
        e_rdy  = up && !fl && model.size() < D;
        e_drop = 8'(m_drop);
        o_cnt = count; o_pv = bus.pop_valid; o_pd = bus.pop_data; o_rdy = bus.push_ready; o_drop = drop_cnt;
        @(posedge clk);
        if (fl) model.delete();
        else if (!(cut && pr)) begin
            if (pr && model.size() > 0) void'(model.pop_front());
            if (pv && e_rdy) model.push_back(pd);
        end
        if (pv && !e_rdy && !fl && m_drop < 255) m_drop++;
        up = (rst_n === 1'b1);
        #1;
    endtask

    task automatic test_reset();
        bus.push_valid = 1'b0; bus.pop_ready = 1'b0; bus.push_data = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({count, drop_cnt, bus.pop_valid, bus.push_ready} !== {4'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset: cnt=%0d drop=%0d pv=%b rdy=%b want 0/0/0/0", count, drop_cnt, bus.pop_valid, bus.push_ready);
        end
        rst_n = 1'b1;
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        total++;
        if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready: rdy=%b want 1", o_rdy); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 11; i++) step(1, W'(16'h0A00 + i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        step(1, 16'h0BBB, 1, 0);
        total++;
        if ({o_cnt, o_drop} !== {4'd4, 8'd3}) begin bad++; $display("FAIL areset_setup: cnt=%0d drop=%0d want 4/3", o_cnt, o_drop); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({count, drop_cnt, bus.pop_valid, bus.push_ready} !== {4'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL areset: cnt=%0d drop=%0d pv=%b rdy=%b want 0/0/0/0", count, drop_cnt, bus.pop_valid, bus.push_ready);
        end
        model.delete(); m_drop = 0; up = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            total++;
            if ({o_cnt, o_pv, o_rdy, o_drop} !== {e_cnt, e_pv, e_rdy, e_drop}) begin
                bad++; $display("FAIL areset_after: cnt/pv/rdy/drop %0d/%b/%b/%0d want %0d/%b/%b/%0d", o_cnt, o_pv, o_rdy, o_drop, e_cnt, e_pv, e_rdy, e_drop);
            end
        end
    endtask

    task automatic test_order();
        logic [3:0] cnts [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        logic [W-1:0] vals [3] = '{16'h0010, 16'h0020, 16'h0030};
        for (int i = 0; i < 7; i++) begin
            if (i < 3) step(1, vals[i], 0, 0);
            else step(0, '0, i < 6, 0);
            total++;
            if (o_cnt !== cnts[i] || (i >= 3 && i < 6 && (o_pv !== 1'b1 || o_pd !== vals[i-3]))) begin
                bad++; $display("FAIL order[%0d]: cnt=%0d pv=%b data=%h want cnt=%0d", i, o_cnt, o_pv, o_pd, cnts[i]);
            end
        end
    endtask

    task automatic test_full();
        int d0 = m_drop;
        for (int i = 0; i < 10; i++) begin
            step(1, W'(16'h0100 + i), 0, 0);
            total++;
            if ({o_cnt, o_rdy} !== {4'(i < 8 ? i : 8), 1'(i < 8)}) begin
                bad++; $display("FAIL full_fill[%0d]: cnt=%0d rdy=%b", i, o_cnt, o_rdy);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1, 0);
            total++;
            if (o_pd !== W'(16'h0100 + i) || o_pv !== 1'b1 || o_drop !== 8'(d0 + 2)) begin
                bad++; $display("FAIL full_drain[%0d]: data=%h pv=%b drop=%0d want %h/1/%0d", i, o_pd, o_pv, o_drop, 16'h0100 + i, d0 + 2);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) step(1, W'(16'h0200 + i), 0, 0);
        for (int i = 0; i < 28; i++) begin
            if (i < 20) step(1, W'(16'h0300 + i), 1, 0);
            else step(0, '0, 1, 0);
            total++;
            if ({o_cnt, o_pv, o_rdy, o_drop} !== {e_cnt, e_pv, e_rdy, e_drop} || (e_pv && o_pd !== e_pd)) begin
                bad++; $display("FAIL wrap[%0d]: cnt/pv/rdy/drop/data %0d/%b/%b/%0d/%h want %0d/%b/%b/%0d/%h", i, o_cnt, o_pv, o_rdy, o_drop, o_pd, e_cnt, e_pv, e_rdy, e_drop, e_pd);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1, W'(16'h0400 + i), 0, 0);
        step(1, 16'h0555, 1, 1);
        total++;
        if ({o_cnt, o_rdy} !== {4'd5, 1'b0}) begin bad++; $display("FAIL flush_cycle: cnt=%0d rdy=%b want 5/0", o_cnt, o_rdy); end
        step(0, '0, 0, 0);
        total++;
        if ({o_cnt, o_pv} !== {4'd0, 1'b0}) begin bad++; $display("FAIL flush_after: cnt=%0d pv=%b want 0/0", o_cnt, o_pv); end
        step(1, 16'h0666, 0, 0);
        step(0, '0, 1, 0);
        total++;
        if ({o_cnt, o_pv, o_pd} !== {4'd1, 1'b1, 16'h0666}) begin bad++; $display("FAIL flush_nostore: cnt=%0d pv=%b data=%h want 1/1/0666", o_cnt, o_pv, o_pd); end
    endtask

    task automatic test_latency();
        step(1, 16'h1234, 1, 0);
        total++;
        if (BYP ? (o_pv !== 1'b1 || o_pd !== 16'h1234) : (o_pv !== 1'b0)) begin
            bad++; $display("FAIL latency_same: pv=%b data=%h bypass=%b", o_pv, o_pd, BYP);
        end
        step(0, '0, 1, 0);
        total++;
        if (BYP ? ({o_cnt, o_pv} !== {4'd0, 1'b0}) : ({o_cnt, o_pv, o_pd} !== {4'd1, 1'b1, 16'h1234})) begin
            bad++; $display("FAIL latency_next: cnt=%0d pv=%b data=%h bypass=%b", o_cnt, o_pv, o_pd, BYP);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, W'($urandom), $urandom % 2, ($urandom % 32) == 0);
            total++;
            if ({o_cnt, o_pv, o_rdy, o_drop} !== {e_cnt, e_pv, e_rdy, e_drop} || (e_pv && o_pd !== e_pd)) begin
                bad++; $display("FAIL random[%0d]: cnt/pv/rdy/drop/data %0d/%b/%b/%0d/%h want %0d/%b/%b/%0d/%h", i, o_cnt, o_pv, o_rdy, o_drop, o_pd, e_cnt, e_pv, e_rdy, e_drop, e_pd);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 270; i++) step(1, W'(i), 0, 0);
        step(0, '0, 0, 0);
        total++;
        if (o_drop !== 8'd255 || o_cnt !== 4'd8) begin bad++; $display("FAIL saturate: drop=%0d cnt=%0d want 255/8", o_drop, o_cnt); end
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        total++;
        if (o_drop !== 8'd255 || o_cnt !== 4'd0) begin bad++; $display("FAIL flush_keeps_drop: drop=%0d cnt=%0d want 255/0", o_drop, o_cnt); end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_order();
        test_full();
        test_wrap();
        test_flush();
        test_latency();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
